// File: rtl/dht11_pkg.sv
// Shared types and constants for the DHT11 transfer controller.
// States, error codes, frame size and the checksum helper.
package dht11_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START_LOW,
    WAIT_ACK,
    ACK_LOW,
    ACK_HIGH,
    BIT_LOW,
    BIT_HIGH,
    CHECK,
    ERR,
    DONE
  } state_e;

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_RESP = 2'd1;
  localparam logic [1:0] ERR_BIT  = 2'd2;
  localparam logic [1:0] ERR_CSUM = 2'd3;

  localparam int FRAME_BITS = 40;

  typedef struct packed {
    logic [7:0] hum_int;
    logic [7:0] hum_dec;
    logic [7:0] tmp_int;
    logic [7:0] tmp_dec;
  } dht11_data_t;

  function automatic logic csum_ok(
    input logic [FRAME_BITS-1:0] f
  );
    logic [7:0] s;
    s = f[39:32] + f[31:24]
      + f[23:16] + f[15:8];
    return s == f[7:0];
  endfunction

endpackage

// File: rtl/dht11_xfer_ctrl_if.sv
// Trigger, pad and result bundle of the DHT11 transfer controller.
// master = user/pad side, slave = controller.
interface dht11_xfer_ctrl_if;

  logic       start;
  logic       dq_in;
  logic       dq_oe;
  logic       busy;
  logic       done;
  logic [1:0] err;
  logic [7:0] hum_int;
  logic [7:0] hum_dec;
  logic [7:0] tmp_int;
  logic [7:0] tmp_dec;

  modport master (
    output start,
    output dq_in,
    input  dq_oe,
    input  busy,
    input  done,
    input  err,
    input  hum_int,
    input  hum_dec,
    input  tmp_int,
    input  tmp_dec
  );

  modport slave (
    input  start,
    input  dq_in,
    output dq_oe,
    output busy,
    output done,
    output err,
    output hum_int,
    output hum_dec,
    output tmp_int,
    output tmp_dec
  );

endinterface

// File: rtl/dht11_us_timer.sv
// Prescaled microsecond timer: one tick per CLK_PER_US clocks,
// 16-bit saturating count, cleared (prescaler too) by clr.
module dht11_us_timer #(
  parameter int CLK_PER_US = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  output logic [15:0] us_cnt
);

  localparam int PW =
    (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;
  logic [15:0]   cnt_q;
  logic [15:0]   cnt_d;
  logic          tick;

  always_comb begin
    tick  = (pre_q == PW'(CLK_PER_US - 1));
    pre_d = tick ? '0 : pre_q + 1'b1;
    cnt_d = cnt_q;
    if (tick && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
    if (clr) begin
      pre_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

  assign us_cnt = cnt_q;

endmodule

// File: rtl/dht11_xfer_ctrl.sv
// DHT11 single-transaction controller: start pulse, ack, 40 bits, checksum.
// Optional DHT11_DQ_SYNC_EN adds a 2-flop synchroniser on dq_in.
module dht11_xfer_ctrl
  import dht11_pkg::*;
#(
  parameter int CLK_PER_US    = 1,
  parameter int START_LOW_US  = 18000,
  parameter int TIMEOUT_US    = 100,
  parameter int BIT_THRESH_US = 40
) (
  input logic               clk,
  input logic               rst,
  dht11_xfer_ctrl_if.slave  bus
);

  state_e                  state_q;
  state_e                  state_d;
  logic [FRAME_BITS-1:0]   bits_q;
  logic [FRAME_BITS-1:0]   bits_d;
  logic [5:0]              bcnt_q;
  logic [5:0]              bcnt_d;
  logic [1:0]              err_q;
  logic [1:0]              err_d;
  dht11_data_t             data_q;
  dht11_data_t             data_d;

  logic [15:0]             us_cnt;
  logic                    tmr_clr;
  logic                    dq;
  logic                    tmo;
  logic [16:0]             hi_us;
  logic                    hi_one;

`ifdef DHT11_DQ_SYNC_EN
  logic [1:0] sync_q;

  // While we drive the pad low the sampled level is our own;
  // park the chain at idle-high so release never looks like an ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else if (bus.dq_oe) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], bus.dq_in};
    end
  end

  assign dq = sync_q[1];
`else
  assign dq = bus.dq_in;
`endif

  dht11_us_timer #(
    .CLK_PER_US (CLK_PER_US)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .us_cnt (us_cnt)
  );

  assign tmr_clr = (state_d != state_q);
  assign tmo     = (us_cnt == 16'(TIMEOUT_US));

  // Entry into BIT_HIGH already lags the rising edge by one us,
  // so the pulse width is the count plus that first interval.
  assign hi_us  = {1'b0, us_cnt} + 17'd1;
  assign hi_one = (hi_us >= 17'(BIT_THRESH_US));

  always_comb begin
    state_d = state_q;
    bits_d  = bits_q;
    bcnt_d  = bcnt_q;
    err_d   = err_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = START_LOW;
          err_d   = ERR_OK;
          bits_d  = '0;
          bcnt_d  = '0;
        end
      end
      START_LOW: begin
        if (us_cnt == 16'(START_LOW_US)) begin
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (!dq) begin
          state_d = ACK_LOW;
        end else if (tmo) begin
          state_d = ERR;
          err_d   = ERR_RESP;
        end
      end
      ACK_LOW: begin
        if (dq) begin
          state_d = ACK_HIGH;
        end else if (tmo) begin
          state_d = ERR;
          err_d   = ERR_RESP;
        end
      end
      ACK_HIGH: begin
        if (!dq) begin
          state_d = BIT_LOW;
        end else if (tmo) begin
          state_d = ERR;
          err_d   = ERR_RESP;
        end
      end
      BIT_LOW: begin
        if (dq) begin
          state_d = BIT_HIGH;
        end else if (tmo) begin
          state_d = ERR;
          err_d   = ERR_BIT;
        end
      end
      BIT_HIGH: begin
        if (!dq) begin
          bits_d  = {bits_q[FRAME_BITS-2:0], hi_one};
          bcnt_d  = bcnt_q + 6'd1;
          state_d = (bcnt_q == 6'(FRAME_BITS - 1))
                  ? CHECK : BIT_LOW;
        end else if (tmo) begin
          state_d = ERR;
          err_d   = ERR_BIT;
        end
      end
      CHECK: begin
        state_d = DONE;
        if (csum_ok(bits_q)) begin
          err_d  = ERR_OK;
          data_d = bits_q[FRAME_BITS-1:8];
        end else begin
          err_d  = ERR_CSUM;
        end
      end
      ERR: begin
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bits_q  <= '0;
      bcnt_q  <= '0;
      err_q   <= ERR_OK;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      bits_q  <= bits_d;
      bcnt_q  <= bcnt_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  // Release one us early so the low time is exactly START_LOW_US.
  assign bus.dq_oe   = (state_q == START_LOW)
                    && (us_cnt != 16'(START_LOW_US));
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.err     = err_q;
  assign bus.hum_int = data_q.hum_int;
  assign bus.hum_dec = data_q.hum_dec;
  assign bus.tmp_int = data_q.tmp_int;
  assign bus.tmp_dec = data_q.tmp_dec;

endmodule

// File: tb/tb_dht11_xfer_ctrl.sv
// Scoreboard bench for dht11_xfer_ctrl with a behavioural DHT11 sensor.
// Directed frames, timeouts, async reset and start-while-busy cases.
module tb_dht11_xfer_ctrl;

  typedef struct packed {
    logic [1:0]  err;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sens = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   oe_cyc = 0;
  int   ndone = 0;
  bit   post_done = 1'b0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  dht11_xfer_ctrl_if bus();

  assign bus.dq_in = bus.dq_oe ? 1'b0 : sens;

  dht11_xfer_ctrl #(
    .CLK_PER_US    (1),
    .START_LOW_US  (50),
    .TIMEOUT_US    (100),
    .BIT_THRESH_US (40)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  function automatic logic [31:0] bytes_now();
    return {bus.hum_int, bus.hum_dec, bus.tmp_int, bus.tmp_dec};
  endfunction

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (post_done) begin
      chk("busy_after_done", 32'(bus.busy), 32'd0);
      post_done = 1'b0;
    end
    if (bus.dq_oe) oe_cyc++;
    if (bus.done) begin
      ndone++;
      post_done = 1'b1;
      chk("exp_available", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("err", 32'(bus.err), 32'(e.err));
        chk("bytes", bytes_now(), e.data);
        chk("start_low_us", 32'(oe_cyc), 32'd50);
      end
    end
  end

  task automatic do_start();
    oe_cyc = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Sensor: waits for host release, acks 80/80, sends frame MSB first.
  // stall >= 0 holds that bit high 150 us; rst_at >= 0 resets in that bit.
  task automatic sensor(input logic [39:0] f, input int w1, input int w0,
                        input int stall, input int rst_at);
    int n;
    n = 0;
    while (bus.dq_oe && n < 1000) begin
      tick();
      n++;
    end
    chk("host_release", 32'(n < 1000), 32'd1);
    hold(20);
    sens = 1'b0;
    hold(80);
    sens = 1'b1;
    hold(80);
    for (int i = 0; i < 40; i++) begin
      sens = 1'b0;
      if (i == rst_at) begin
        hold(20);
        rst = 1'b1;
        #1;
        chk("rst_dq_oe", 32'(bus.dq_oe), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_bytes", bytes_now(), 32'd0);
        sens = 1'b1;
        tick();
        rst = 1'b0;
        return;
      end
      hold(50);
      sens = 1'b1;
      if (i == stall) begin
        hold(150);
        return;
      end
      hold(f[39-i] ? w1 : w0);
    end
    sens = 1'b0;
    hold(50);
    sens = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 20000) begin
      tick();
      n++;
    end
    chk("idle_in_time", 32'(n < 20000), 32'd1);
    hold(5);
  endtask

  localparam logic [39:0] F_OK  = 40'h37_00_19_00_50;
  localparam logic [39:0] F_BAD = 40'h37_00_19_00_51;
  localparam logic [39:0] F_ALT = 40'h41_02_17_05_5F;

  initial begin
    int n;
    bit seen;
    bus.start = 1'b0;
    #1;
    chk("reset_dq_oe", 32'(bus.dq_oe), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_err", 32'(bus.err), 32'd0);
    chk("reset_bytes", bytes_now(), 32'd0);
    hold(3);
    rst = 1'b0;
    hold(3);

    // good frame
    exp_q.push_back('{err: 2'd0, data: 32'h37_00_19_00});
    do_start();
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    chk("oe_after_start", 32'(bus.dq_oe), 32'd1);
    sensor(F_OK, 70, 26, -1, -1);
    wait_idle();

    // checksum failure keeps previous bytes
    exp_q.push_back('{err: 2'd3, data: 32'h37_00_19_00});
    do_start();
    sensor(F_BAD, 70, 26, -1, -1);
    wait_idle();

    // no response: done 103 cycles after release
    exp_q.push_back('{err: 2'd1, data: 32'h37_00_19_00});
    do_start();
    n = 0;
    while (bus.dq_oe && n < 1000) begin
      tick();
      n++;
    end
    n = 0;
    while (!bus.done && n < 1000) begin
      tick();
      n++;
    end
    chk("resp_timeout_lat", 32'(n), 32'd103);
    wait_idle();

    // stall during bit 17
    exp_q.push_back('{err: 2'd2, data: 32'h37_00_19_00});
    do_start();
    sensor(F_OK, 70, 26, 17, -1);
    wait_idle();

    // async reset during bit 10, then a clean transaction
    do_start();
    sensor(F_OK, 70, 26, -1, 10);
    hold(5);
    exp_q.push_back('{err: 2'd0, data: 32'h41_02_17_05});
    do_start();
    sensor(F_ALT, 70, 26, -1, -1);
    wait_idle();

    // 40 us reads as 1, 39 us as 0; stray starts while busy/done
    exp_q.push_back('{err: 2'd0, data: 32'h37_00_19_00});
    do_start();
    fork
      sensor(F_OK, 40, 39, -1, -1);
      begin
        hold(300);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 10000) begin
          tick();
          n++;
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
      end
    join
    wait_idle();
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (bus.busy) seen = 1'b1;
    end
    chk("no_extra_txn", 32'(seen), 32'd0);
    chk("done_count", 32'(ndone), 32'd6);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
